prime_request_sequencer: RTL and testbench

Upstream driver and result collector for the next-prime search engine. It selects a 7-bit seed, either from an internal LFSR or an external input, and drives the engine's number input and one-cycle find enable. It then waits a fixed settle window and samples the engine's prime output into a one-entry valid/ready result register. It is the only block that issues requests to the engine and the only consumer of its output.

---
 rtl/prime_pkg.sv | 26 ++
 rtl/prime_lfsr7.sv | 29 ++
 rtl/prime_request_sequencer.sv | 121 ++++++++++++
 tb/tb_prime_request_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime request sequencer: widths, LFSR taps,
// FSM state encoding and the range check applied to every engine result.
package prime_pkg;

    localparam int NUM_W       = 7;
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    // Composite seeds at or above this value make the engine wrap its search to 2.
    localparam logic [NUM_W-1:0] WRAP_THRESHOLD = NUM_W'(100);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE
    } seq_state_t;

    function automatic logic range_ok(input logic [NUM_W-1:0] seed,
                                      input logic [NUM_W-1:0] prime);
        logic [NUM_W-1:0] eff;
        eff = (seed <= NUM_W'(2)) ? NUM_W'(2) : seed;
        return (prime >= eff) || ((seed >= WRAP_THRESHOLD) && (prime == NUM_W'(2)));
    endfunction

endpackage

// File: rtl/prime_lfsr7.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1) supplying pseudo-random seeds; advances
// only when the sequencer consumes its current value.
module prime_lfsr7
    import prime_pkg::*;
#(
    parameter logic [NUM_W-1:0] INIT = 7'h5A
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    output logic [NUM_W-1:0] o_q
);

    logic [NUM_W-1:0] r_q;
    logic             w_feedback;

    assign w_feedback = r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= INIT;
        end else if (i_step) begin
            r_q <= {r_q[NUM_W-2:0], w_feedback};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/prime_request_sequencer.sv
// Issues seed requests to the next-prime engine, waits out its settle window
// and collects the engine's prime into a one-entry valid/ready result register.
module prime_request_sequencer
    import prime_pkg::*;
#(
    parameter int               WAIT_CYCLES = 300,
    parameter logic [NUM_W-1:0] LFSR_SEED   = 7'h5A
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_seed_sel,
    input  logic [NUM_W-1:0] i_ext_seed,
    output logic [NUM_W-1:0] o_seed_out,
    output logic             o_find_en,
    input  logic [NUM_W-1:0] i_prime_in,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [NUM_W-1:0] o_res_seed,
    output logic [NUM_W-1:0] o_res_prime,
    output logic             o_res_ok,
    output logic             o_busy
);

    localparam int               CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [NUM_W-1:0] r_seed;
    logic [NUM_W-1:0] w_lfsr_q;
    logic             w_launch_req;
    logic             w_lfsr_step;
    logic             w_capture_wr;
    logic             w_transfer;
    logic             r_res_valid;
    logic [NUM_W-1:0] r_res_seed;
    logic [NUM_W-1:0] r_res_prime;
    logic             r_res_ok;

    assign w_launch_req = (r_state == IDLE) && (i_start || i_run);
    assign w_lfsr_step  = w_launch_req && !i_seed_sel;
    assign w_capture_wr = (r_state == CAPTURE) && (!r_res_valid || i_res_ready);
    assign w_transfer   = r_res_valid && i_res_ready;

    prime_lfsr7 #(
        .INIT (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_step (w_lfsr_step),
        .o_q    (w_lfsr_q)
    );

    // WAIT leaves when the counter is about to hit zero, so prime_in is sampled
    // exactly WAIT_CYCLES cycles after find_en.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_launch_req) w_next_state = LAUNCH;
            LAUNCH:  w_next_state = (WAIT_CYCLES == 1) ? CAPTURE : WAIT;
            WAIT:    if (r_wait_cnt <= CNT_W'(1)) w_next_state = CAPTURE;
            CAPTURE: if (w_capture_wr) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_wait_cnt <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seed <= '0;
        end else if (w_launch_req) begin
            r_seed <= i_seed_sel ? i_ext_seed : w_lfsr_q;
        end
    end

    // A write in the same cycle as a transfer keeps valid high with the new data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_seed  <= '0;
            r_res_prime <= '0;
            r_res_ok    <= 1'b0;
        end else if (w_capture_wr) begin
            r_res_valid <= 1'b1;
            r_res_seed  <= r_seed;
            r_res_prime <= i_prime_in;
            r_res_ok    <= range_ok(r_seed, i_prime_in);
        end else if (w_transfer) begin
            r_res_valid <= 1'b0;
        end
    end

    assign o_seed_out  = r_seed;
    assign o_find_en   = (r_state == LAUNCH);
    assign o_busy      = (r_state != IDLE);
    assign o_res_valid = r_res_valid;
    assign o_res_seed  = r_res_seed;
    assign o_res_prime = r_res_prime;
    assign o_res_ok    = r_res_ok;

endmodule

// File: tb/tb_prime_request_sequencer.sv
// Self-checking bench: directed and randomized requests against a behavioural
// engine/result model derived from the sequencer's externally visible rules.
module tb_prime_request_sequencer;

    localparam int         W         = 300;
    localparam logic [6:0] LFSR_INIT = 7'h5A;

    logic       clk;
    logic       rst;
    logic       start;
    logic       run;
    logic       seedSel;
    logic [6:0] extSeed;
    logic [6:0] seedOut;
    logic       findEn;
    logic [6:0] primeIn;
    logic       resValid;
    logic       resReady;
    logic [6:0] resSeed;
    logic [6:0] resPrime;
    logic       resOk;
    logic       busy;

    logic       forceEn;
    logic [6:0] forceVal;
    logic [6:0] lfsrModel;
    int         findCount;
    int         checks;
    int         failures;

    prime_request_sequencer #(
        .WAIT_CYCLES (W),
        .LFSR_SEED   (LFSR_INIT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_run       (run),
        .i_seed_sel  (seedSel),
        .i_ext_seed  (extSeed),
        .o_seed_out  (seedOut),
        .o_find_en   (findEn),
        .i_prime_in  (primeIn),
        .o_res_valid (resValid),
        .i_res_ready (resReady),
        .o_res_seed  (resSeed),
        .o_res_prime (resPrime),
        .o_res_ok    (resOk),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (findEn === 1'b1) findCount++;

    function automatic bit isPrime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Engine behaviour: smallest prime >= max(seed,2); composite seeds >= 100 wrap to 2.
    function automatic int enginePrime(input int s);
        int n;
        if (s >= 100 && !isPrime(s)) return 2;
        n = (s < 2) ? 2 : s;
        while (!isPrime(n)) n++;
        return n;
    endfunction

    function automatic bit expectOk(input int s, input int p);
        int eff;
        eff = (s <= 2) ? 2 : s;
        return (p >= eff) || (s >= 100 && p == 2);
    endfunction

    function automatic logic [6:0] lfsrNext(input logic [6:0] q);
        int v;
        v = int'(q);
        return 7'(((v * 2) % 128) + (((v / 64) + (v / 32)) % 2));
    endfunction

    always_comb begin
        primeIn = forceEn ? forceVal : 7'(enginePrime(int'(seedOut)));
    end

    task automatic applyStimulus(input logic st, input logic rn, input logic sel, input logic [6:0] ext);
        start   = st;
        run     = rn;
        seedSel = sel;
        extSeed = ext;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_seed_out"}, 32'(seedOut), 32'd0);
        checkOutput({tag, "_find_en"}, 32'(findEn), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(resValid), 32'd0);
        checkOutput({tag, "_res_seed"}, 32'(resSeed), 32'd0);
        checkOutput({tag, "_res_prime"}, 32'(resPrime), 32'd0);
        checkOutput({tag, "_res_ok"}, 32'(resOk), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One complete request: start at cycle t, result expected from t+2+W.
    task automatic doRequest(input string tag, input logic sel, input logic [6:0] ext,
                             input logic doForce, input logic [6:0] fVal,
                             input int readyDelay, input bit pokeStart);
        logic [6:0] expSeed;
        int         expPrime;
        int         f0;
        expSeed = sel ? ext : lfsrModel;
        if (!sel) lfsrModel = lfsrNext(lfsrModel);
        forceEn  = doForce;
        forceVal = fVal;
        expPrime = doForce ? int'(fVal) : enginePrime(int'(expSeed));
        f0 = findCount;
        applyStimulus(1'b1, 1'b0, sel, ext);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, sel, ext);
        checkOutput({tag, "_find_en_hi"}, 32'(findEn), 32'd1);
        checkOutput({tag, "_seed_out"}, 32'(seedOut), 32'(expSeed));
        for (int k = 0; k < W - 1; k++) begin
            @(negedge clk);
            start = (pokeStart && k == 5) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        checkOutput({tag, "_not_early"}, 32'(resValid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_capture_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_res_valid"}, 32'(resValid), 32'd1);
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_one_find_en"}, 32'(findCount - f0), 32'd1);
        repeat (readyDelay) @(negedge clk);
        checkOutput({tag, "_res_seed"}, 32'(resSeed), 32'(expSeed));
        checkOutput({tag, "_res_prime"}, 32'(resPrime), 32'(expPrime));
        checkOutput({tag, "_res_ok"}, 32'(resOk), 32'(expectOk(int'(expSeed), expPrime)));
        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        forceEn  = 1'b0;
        checkOutput({tag, "_drained"}, 32'(resValid), 32'd0);
    endtask

    initial begin
        int f1;
        checks    = 0;
        failures  = 0;
        findCount = 0;
        forceEn   = 1'b0;
        forceVal  = '0;
        resReady  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        lfsrModel = LFSR_INIT;
        @(negedge clk);

        doRequest("ext14", 1'b1, 7'd14, 1'b0, 7'd0, 0, 1'b0);
        doRequest("ext0", 1'b1, 7'd0, 1'b0, 7'd0, 0, 1'b0);
        doRequest("ext100", 1'b1, 7'd100, 1'b0, 7'd0, 2, 1'b0);
        doRequest("ext50_f47", 1'b1, 7'd50, 1'b1, 7'd47, 0, 1'b0);
        doRequest("lfsr0", 1'b0, 7'd0, 1'b0, 7'd0, 0, 1'b0);
        doRequest("lfsr1", 1'b0, 7'd0, 1'b0, 7'd0, 0, 1'b0);
        doRequest("lfsr2", 1'b0, 7'd0, 1'b0, 7'd0, 0, 1'b0);
        doRequest("poke", 1'b1, 7'd90, 1'b0, 7'd0, 0, 1'b1);

        // Backpressure: run mode with the consumer stalled.
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd30);
        @(negedge clk);
        extSeed = 7'd60;
        checkOutput("bp_find_en", 32'(findEn), 32'd1);
        repeat (W + 1) @(negedge clk);
        checkOutput("bp_first_valid", 32'(resValid), 32'd1);
        f1 = findCount;
        repeat (2 * W) @(negedge clk);
        run = 1'b0;
        checkOutput("bp_one_more_find", 32'(findCount - f1), 32'd1);
        checkOutput("bp_held_busy", 32'(busy), 32'd1);
        checkOutput("bp_held_valid", 32'(resValid), 32'd1);
        checkOutput("bp_held_seed", 32'(resSeed), 32'd30);
        checkOutput("bp_held_prime", 32'(resPrime), 32'd31);
        checkOutput("bp_pending_seed", 32'(seedOut), 32'd60);
        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        checkOutput("bp_swap_valid", 32'(resValid), 32'd1);
        checkOutput("bp_swap_seed", 32'(resSeed), 32'd60);
        checkOutput("bp_swap_prime", 32'(resPrime), 32'd61);
        checkOutput("bp_swap_ok", 32'(resOk), 32'd1);
        checkOutput("bp_swap_idle", 32'(busy), 32'd0);
        f1 = findCount;
        repeat (3) @(negedge clk);
        checkOutput("bp_no_relaunch", 32'(findCount - f1), 32'd0);
        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        checkOutput("bp_drained", 32'(resValid), 32'd0);

        // Reset mid-WAIT aborts an LFSR request and rewinds the LFSR.
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lfsrModel = LFSR_INIT;
        f1 = findCount;
        repeat (W + 5) @(negedge clk);
        checkOutput("abort_no_find", 32'(findCount - f1), 32'd0);
        checkOutput("abort_no_result", 32'(resValid), 32'd0);
        doRequest("lfsr_after_rst", 1'b0, 7'd0, 1'b0, 7'd0, 0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            doRequest("rand", 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                      ($urandom_range(0, 3) == 0), 7'($urandom_range(0, 127)),
                      int'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
